// File: rtl/sat_accum_fsm.sv
// sat_accum_fsm: multi-channel accumulator sequencer.
// A run accepts BURST_LEN beats from a valid/ready source. Each beat is added
// into the accumulator of its channel at WIDTH+1 bits. Afterwards the block
// presents one result per channel, in channel order, to a valid/ready consumer.
// Overflow either clamps to all-ones (SAT_MODE=1) or wraps (SAT_MODE=0).
// In both modes a per-channel sticky flag records the carry.
module sat_accum_fsm #(
    parameter int WIDTH     = 4,
    parameter int CHANNELS  = 2,
    parameter int BURST_LEN = 4,
    parameter int SAT_MODE  = 1,
    parameter int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CW-1:0]    in_chan,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_chan,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic             chan_err,
    output logic             busy
);

    // The beat counter must be able to hold the value BURST_LEN itself.
    localparam int BCW   = (BURST_LEN > 1) ? $clog2(BURST_LEN + 1) : 1;
    // in_chan can encode more slots than there are channels.
    localparam int NSLOT = 1 << CW;

    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST_LEN - 1);
    localparam logic [CW-1:0]  LAST_CHAN = CW'(CHANNELS - 1);

    // Build a constant table with one bit per in_chan code.
    // Checking a channel is then a single lookup, not a range compare.
    function automatic logic [NSLOT-1:0] legal_chan_mask();
        logic [NSLOT-1:0] m;
        m = '0;
        for (int i = 0; i < NSLOT; i++) begin
            m[i] = (i < CHANNELS);
        end
        return m;
    endfunction

    localparam logic [NSLOT-1:0] CHAN_OK = legal_chan_mask();

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Per-channel accumulators and sticky carry flags.
    logic [WIDTH-1:0]    acc [CHANNELS];
    logic [CHANNELS-1:0] ovf;

    logic [BCW-1:0] beat_cnt;
    logic [CW-1:0]  drain_idx;
    logic           chan_err_q;

    // Handshake and control decodes.
    logic clear_run;
    logic accept;
    logic out_fire;
    logic chan_legal;
    logic last_beat;
    logic last_chan;

    // Adder datapath.
    logic [WIDTH-1:0] sel_acc;
    logic [WIDTH:0]   sum_ext;
    logic             carry;
    logic [WIDTH-1:0] upd_val;

    assign accept     = in_valid & in_ready;
    assign out_fire   = out_valid & out_ready;
    assign chan_legal = CHAN_OK[in_chan];
    assign last_beat  = (beat_cnt == LAST_BEAT);
    assign last_chan  = (drain_idx == LAST_CHAN);

    assign busy     = (state != IDLE);
    assign chan_err = chan_err_q;
    assign out_chan = drain_idx;

    // State register. rst takes priority over every other input.
    // NOTE: clocked state always uses non-blocking (<=) assignments. Every
    // flop then samples values from before the edge, whatever order the
    // blocks are evaluated in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs for IDLE, ACCUM and DRAIN.
    // NOTE: every signal written here gets a default value first. That
    // leaves no path that keeps an old value, so no latch can be inferred.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        clear_run  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear_run  = 1'b1;
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (accept && last_beat) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_fire && last_chan) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Select the accumulator addressed by the incoming beat.
    always_comb begin
        sel_acc = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (in_chan == CW'(i)) begin
                sel_acc = acc[i];
            end
        end
    end

    // Add with one extra bit so the carry is never lost.
    // On a carry, clamp to all-ones or wrap, depending on SAT_MODE.
    // A saturated accumulator stays at all-ones: adding any value carries,
    // and adding zero leaves it unchanged.
    always_comb begin
        sum_ext = {1'b0, sel_acc} + {1'b0, in_data};
        carry   = sum_ext[WIDTH];
        if (carry && (SAT_MODE != 0)) begin
            upd_val = '1;
        end else begin
            upd_val = sum_ext[WIDTH-1:0];
        end
    end

    // Accumulator and carry-flag update.
    // Cleared on reset and on start. Otherwise they keep their values so the
    // consumer can read them back during DRAIN.
    // NOTE: acc is built from flops, not mapped to a RAM. That is why it can
    // be cleared in a reset loop. A RAM array would need a sequenced clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
            end
            ovf <= '0;
        end else if (clear_run) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
            end
            ovf <= '0;
        end else if (accept && chan_legal) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (in_chan == CW'(i)) begin
                    acc[i] <= upd_val;
                    if (carry) begin
                        ovf[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Beat counter and sticky channel-error flag.
    // An out-of-range beat still counts toward the burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt   <= '0;
            chan_err_q <= 1'b0;
        end else if (clear_run) begin
            beat_cnt   <= '0;
            chan_err_q <= 1'b0;
        end else if (accept) begin
            beat_cnt <= beat_cnt + BCW'(1);
            if (!chan_legal) begin
                chan_err_q <= 1'b1;
            end
        end
    end

    // Drain index. It moves forward one step per result handshake and wraps
    // to 0 after the last channel, ready for the next run.
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_idx <= '0;
        end else if (out_fire) begin
            drain_idx <= last_chan ? '0 : drain_idx + CW'(1);
        end
    end

    // Present the result of the current drain channel straight from the
    // registers, so it holds steady while the consumer stalls.
    always_comb begin
        out_sum = '0;
        out_ovf = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (drain_idx == CW'(i)) begin
                out_sum = acc[i];
                out_ovf = ovf[i];
            end
        end
    end

endmodule

// File: doc/sat_accum_fsm.md
Name: sat_accum_fsm

Overview:
- Parametrised multi-channel accumulator sequencer with explicit overflow handling.
- Supersedes ad-hoc single-width adders: full-case FSM, single driver per register, WIDTH+1-bit internal sums, selectable saturate or wrap.
- Sits between a beat-oriented data source and a result consumer. Both sides use valid/ready handshakes.

Parameters:
- WIDTH, 4: data and accumulator width in bits (min 2).
- CHANNELS, 2: number of independent accumulators (min 1). CW = max(1, $clog2(CHANNELS)).
- BURST_LEN, 4: beats accepted per accumulation run (min 1).
- SAT_MODE, 1: 1 = clamp to 2^WIDTH-1 on carry; 0 = wrap modulo 2^WIDTH.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begin a run; sampled only in IDLE.
- in_valid  input  1  source beat valid.
- in_ready  output  1  block accepts beat.
- in_chan  input  CW  target channel of the beat.
- in_data  input  WIDTH  unsigned addend.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_chan  output  CW  channel index of the presented result.
- out_sum  output  WIDTH  accumulated value of out_chan.
- out_ovf  output  1  sticky carry flag of out_chan.
- chan_err  output  1  sticky: a beat arrived with in_chan >= CHANNELS.
- busy  output  1  high in ACCUM or DRAIN.

Behaviour:
- Reset (synchronous, rst=1 at edge):
  - state=IDLE; all acc[], ovf[], beat count, drain index and chan_err cleared.
  - Outputs after reset: in_ready=0, out_valid=0, out_chan=0, out_sum=0, out_ovf=0, chan_err=0, busy=0.
  - rst overrides every other input, in any state, mid-run included.
- FSM, states IDLE, ACCUM, DRAIN. Case is full, with default -> IDLE.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1: clear acc[], ovf[], chan_err and beat count; next state ACCUM.
- ACCUM:
  - in_ready=1, combinationally equal to (state==ACCUM).
  - A beat is accepted when in_valid & in_ready.
  - Accepted beat with in_chan < CHANNELS:
    - s = {1'b0, acc[c]} + {1'b0, in_data}, computed at WIDTH+1 bits.
    - If s[WIDTH]=1: ovf[c] <= 1. acc[c] <= all-ones if SAT_MODE=1, else s[WIDTH-1:0].
    - Once acc[c] has saturated, further adds keep it at all-ones.
  - Accepted beat with in_chan >= CHANNELS: counted toward the burst, not accumulated, chan_err <= 1.
  - The accept that brings the beat count to BURST_LEN moves to DRAIN at the same edge. That beat's update lands at the same edge.
  - in_valid gaps stall the count. There is no timeout.
  - start is ignored in ACCUM.
- DRAIN:
  - out_valid=1. out_chan = drain index, starting at 0.
  - out_sum = acc[out_chan] and out_ovf = ovf[out_chan], both driven from registers.
  - First out_valid occurs 1 cycle after the final accepted beat, and its result includes that beat.
  - On out_valid & out_ready: index++. After index CHANNELS-1 completes its handshake, next state IDLE and index reset to 0.
  - While out_ready=0, out_chan, out_sum and out_ovf are held stable.
  - in_ready=0 and start is ignored in DRAIN.
- After returning to IDLE:
  - acc[] and ovf[] retain their values until the next start.
  - chan_err stays sticky until the next start or rst.
- busy = (state != IDLE).

Test Plan:
- Wrap mode (SAT_MODE=0, WIDTH=4, CHANNELS=2, BURST_LEN=4):
  - Stimulus: start, then beats (ch0,9), (ch1,3), (ch0,8), (ch1,4).
  - Required: two results, ch0 sum=1 ovf=1, then ch1 sum=7 ovf=0; back in IDLE after the second handshake.
- Saturate mode (SAT_MODE=1), same stimulus:
  - Required: ch0 sum=15 ovf=1, ch1 sum=7 ovf=0.
  - A further run with beats (ch0,15)x4 gives ch0 sum=15 ovf=1.
- Backpressure:
  - Stimulus: hold out_ready=0 for 3 cycles in DRAIN.
  - Required: out_valid=1 and out_chan/out_sum/out_ovf unchanged every cycle; exactly one advance per out_ready pulse.
- Input gaps and ignored start:
  - Stimulus: in_valid toggled 1,0,0,1,1,0,1; start pulsed during ACCUM and during DRAIN.
  - Required: DRAIN entered 1 cycle after the 4th accept; the start pulses have no effect.
- Reset mid-ACCUM:
  - Stimulus: rst=1 for one cycle after 2 beats.
  - Required: at the next edge state=IDLE, busy=0, in_ready=0, out_valid=0, chan_err=0; a subsequent run starts from zero sums.
- Illegal channel (CHANNELS=3, CW=2):
  - Stimulus: beats (ch3,5), (ch0,2), (ch1,1), (ch2,4).
  - Required: chan_err=1; results ch0=2, ch1=1, ch2=4; beat count still reaches 4; chan_err cleared on the next start.
